// File: rtl/soc_sram_sp_ahb3_bridge.sv
// AHB3-Lite slave to single-port synchronous SRAM (read data one cycle after issue).
// Zero-wait reads/writes; one wait state for a read whose address phase meets a write data phase.
module soc_sram_sp_ahb3_bridge #(
  parameter int PLEN    = 32,
  parameter int XLEN    = 32,
  parameter int WORD_AW = PLEN - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               HSEL,
  input  logic [PLEN-1:0]    HADDR,
  input  logic [XLEN-1:0]    HWDATA,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [3:0]         HPROT,
  input  logic [1:0]         HTRANS,
  input  logic               HMASTLOCK,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [XLEN-1:0]    HRDATA,
  output logic               sram_ce,
  output logic               sram_we,
  output logic               sram_oe,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [XLEN-1:0]    sram_din,
  output logic [3:0]         sram_sel,
  input  logic [XLEN-1:0]    sram_dout
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, READ_STALL, ERR1, ERR2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WORD_AW-1:0] r_waddr;
  logic [3:0]         r_sel;

  logic               w_ready;
  logic               w_acc;
  logic               w_err;
  logic [3:0]         w_lanes;
  logic [WORD_AW-1:0] w_haddr_word;
  logic               w_unused;

  assign w_unused     = ^{HBURST, HPROT, HMASTLOCK, HADDR};
  assign w_haddr_word = HADDR[WORD_AW+1:2];

  // The bridge is the only stalling agent, so its own wait states also block acceptance.
  assign w_ready = (r_state != READ_STALL) && (r_state != ERR1);
  assign w_acc   = HSEL & HREADY & HTRANS[1] & w_ready;

  always_comb begin
    w_lanes = 4'b0000;
    w_err   = 1'b0;
    case (HSIZE)
      3'd0: w_lanes = 4'b0001 << HADDR[1:0];
      3'd1: begin
        w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
        w_err   = HADDR[0];
      end
      3'd2: begin
        w_lanes = 4'b1111;
        w_err   = |HADDR[1:0];
      end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_waddr <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_waddr <= w_haddr_word;
        r_sel   <= w_lanes;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      READ_STALL: w_next = READ;
      ERR1:       w_next = ERR2;
      default: begin
        w_next = IDLE;
        if (w_acc) begin
          if (w_err)                 w_next = ERR1;
          else if (HWRITE)           w_next = WRITE;
          else if (r_state == WRITE) w_next = READ_STALL;
          else                       w_next = READ;
        end
      end
    endcase
  end

  assign HREADYOUT = w_ready;
  assign HRESP     = (r_state == ERR1) || (r_state == ERR2);
  assign HRDATA    = (r_state == READ) ? sram_dout : '0;

  // A pending write data phase owns the SRAM port; a colliding read waits in READ_STALL.
  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_oe    = 1'b0;
    sram_waddr = '0;
    sram_din   = '0;
    sram_sel   = 4'b0000;
    if (!rst) begin
      if (r_state == WRITE) begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_waddr = r_waddr;
        sram_din   = HWDATA;
        sram_sel   = r_sel;
      end else if (r_state == READ_STALL) begin
        sram_ce    = 1'b1;
        sram_oe    = 1'b1;
        sram_waddr = r_waddr;
      end else if (w_acc && !w_err && !HWRITE) begin
        sram_ce    = 1'b1;
        sram_oe    = 1'b1;
        sram_waddr = w_haddr_word;
      end
    end
  end

endmodule
